// File: rtl/sram_port_arbiter_pkg.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | sram_port_arbiter_pkg: shared types for the SRAM port arbiter          |
// | Rev 1.0                                                               |
// +-----------------------------------------------------------------------+
package sram_port_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    LOCKED_A = 2'd1,
    LOCKED_B = 2'd2
  } arb_state_e;

  localparam logic REQ_A = 1'b0;
  localparam logic REQ_B = 1'b1;

endpackage
`default_nettype wire

// File: rtl/sram_port_arbiter_rr_select.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | sram_rr_select: two-way round-robin pick from requests and last winner |
// | Rev 1.0                                                               |
// +-----------------------------------------------------------------------+
module sram_rr_select
  import sram_port_arbiter_pkg::*;
(
  input  logic       requestA_i,
  input  logic       requestB_i,
  input  logic       lastGrant_i,
  output logic [1:0] grant_o,
  output logic       winner_o
);

  always_comb begin
    winner_o = REQ_A;
    // On a tie the requester that did not win last time goes first
    if (requestA_i && requestB_i) begin
      winner_o = ~lastGrant_i;
    end else if (requestB_i) begin
      winner_o = REQ_B;
    end
    grant_o = 2'b00;
    if (requestA_i || requestB_i) begin
      grant_o = (winner_o == REQ_B) ? 2'b10 : 2'b01;
    end
  end

endmodule
`default_nettype wire

// File: rtl/sram_port_arbiter.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | sram_port_arbiter: shares one SSRAM port between requesters A and B    |
// | Rev 1.0                                                               |
// +-----------------------------------------------------------------------+
module sram_port_arbiter
  import sram_port_arbiter_pkg::*;
#(
  parameter  int BITWIDTH        = 32,
  parameter  int NR_OF_ENTRIES   = 512,
  parameter  int MAX_LOCK_CYCLES = 16,
  localparam int AW              = $clog2(NR_OF_ENTRIES)
) (
  input  logic                clock_i,
  input  logic                nReset_i,
  input  logic                requestA_i,
  input  logic                lockA_i,
  input  logic                writeEnableA_i,
  input  logic [AW-1:0]       addressA_i,
  input  logic [BITWIDTH-1:0] dataInA_i,
  output logic                grantA_o,
  output logic                readValidA_o,
  output logic [BITWIDTH-1:0] dataOutA_o,
  input  logic                requestB_i,
  input  logic                lockB_i,
  input  logic                writeEnableB_i,
  input  logic [AW-1:0]       addressB_i,
  input  logic [BITWIDTH-1:0] dataInB_i,
  output logic                grantB_o,
  output logic                readValidB_o,
  output logic [BITWIDTH-1:0] dataOutB_o,
  output logic [AW-1:0]       sramAddress_o,
  output logic                sramWriteEnable_o,
  output logic [BITWIDTH-1:0] sramDataIn_o,
  input  logic [BITWIDTH-1:0] sramDataOut_i
);

  localparam int CW = $clog2(MAX_LOCK_CYCLES + 1);

  arb_state_e          state_q;
  logic                lastGrant_q;
  logic [CW-1:0]       lockCount_q;
  logic                pendingReadA_q;
  logic                pendingReadB_q;
  logic [AW-1:0]       addrHold_q;
  logic [BITWIDTH-1:0] dataHold_q;

  logic [1:0] rrGrant;
  logic       rrWinner;
  logic [1:0] grantVec;
  logic       selId;
  logic       anyGrant;
  logic       selLock;
  logic       selWe;

  sram_rr_select u_rr_select (
    .requestA_i  (requestA_i),
    .requestB_i  (requestB_i),
    .lastGrant_i (lastGrant_q),
    .grant_o     (rrGrant),
    .winner_o    (rrWinner)
  );

  always_comb begin
    grantVec = 2'b00;
    selId    = REQ_A;
    case (state_q)
      IDLE: begin
        grantVec = rrGrant;
        selId    = rrWinner;
      end
      LOCKED_A: begin
        grantVec = {1'b0, requestA_i};
        selId    = REQ_A;
      end
      LOCKED_B: begin
        grantVec = {requestB_i, 1'b0};
        selId    = REQ_B;
      end
      default: ;
    endcase
    if (!nReset_i) begin
      grantVec = 2'b00;
    end
  end

  assign anyGrant = |grantVec;
  assign grantA_o = grantVec[0];
  assign grantB_o = grantVec[1];
  assign selLock  = (selId == REQ_B) ? lockB_i : lockA_i;
  assign selWe    = (selId == REQ_B) ? writeEnableB_i : writeEnableA_i;

  // Idle cycles keep the last address/data on the bus to avoid toggling
  assign sramWriteEnable_o = anyGrant & selWe;
  assign sramAddress_o     = !anyGrant ? addrHold_q :
                             (selId == REQ_B) ? addressB_i : addressA_i;
  assign sramDataIn_o      = !anyGrant ? dataHold_q :
                             (selId == REQ_B) ? dataInB_i : dataInA_i;

  assign readValidA_o = pendingReadA_q;
  assign readValidB_o = pendingReadB_q;
  assign dataOutA_o   = pendingReadA_q ? sramDataOut_i : '0;
  assign dataOutB_o   = pendingReadB_q ? sramDataOut_i : '0;

  always_ff @(posedge clock_i) begin
    if (anyGrant) begin
      addrHold_q <= sramAddress_o;
      dataHold_q <= sramDataIn_o;
    end
  end

  always_ff @(posedge clock_i) begin
    if (!nReset_i) begin
      state_q        <= IDLE;
      lastGrant_q    <= REQ_B;
      lockCount_q    <= '0;
      pendingReadA_q <= 1'b0;
      pendingReadB_q <= 1'b0;
    end else begin
      pendingReadA_q <= grantVec[0] & ~writeEnableA_i;
      pendingReadB_q <= grantVec[1] & ~writeEnableB_i;
      if (anyGrant) begin
        lastGrant_q <= selId;
      end
      case (state_q)
        IDLE: begin
          if (anyGrant && selLock) begin
            state_q     <= (selId == REQ_B) ? LOCKED_B : LOCKED_A;
            lockCount_q <= CW'(1);
          end
        end
        LOCKED_A, LOCKED_B: begin
          // Owner dropped, released, or used up its burst allowance
          if (!anyGrant || !selLock ||
              lockCount_q >= CW'(MAX_LOCK_CYCLES - 1)) begin
            state_q     <= IDLE;
            lockCount_q <= '0;
          end else begin
            lockCount_q <= lockCount_q + CW'(1);
          end
        end
        default: begin
          state_q     <= IDLE;
          lockCount_q <= '0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_sram_port_arbiter.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | tb_sram_port_arbiter: directed vector table plus randomized traffic    |
// | Rev 1.0                                                               |
// +-----------------------------------------------------------------------+
module tb_sram_port_arbiter;

  localparam int BW  = 32;
  localparam int NE  = 512;
  localparam int AW  = 9;
  localparam int MAX = 4;

  typedef struct {
    bit          rst;
    bit          rstLate;
    bit          rA, lA, wA;
    logic [AW-1:0] aA;
    logic [BW-1:0] dA;
    bit          rB, lB, wB;
    logic [AW-1:0] aB;
    logic [BW-1:0] dB;
    bit          gA, gB, vA, vB;
    logic [BW-1:0] oA, oB;
  } vec_t;

  logic          clk = 1'b0;
  logic          nReset;
  logic          requestA, lockA, writeEnableA, requestB, lockB, writeEnableB;
  logic [AW-1:0] addressA, addressB, sramAddress;
  logic [BW-1:0] dataInA, dataInB, sramDataIn, dataOutA, dataOutB;
  logic [BW-1:0] sramDataOut = '0;
  logic          grantA, grantB, readValidA, readValidB, sramWriteEnable;

  int vectors = 0;
  int miscompares = 0;

  logic [BW-1:0] mem [NE];
  logic [BW-1:0] shadow [NE];

  // Reference model: owner 0 none / 1 A / 2 B, last 0 A / 1 B
  int            owner = 0;
  int            beats = 0;
  int            last = 1;
  bit            evA = 0, evB = 0, haveHold = 0;
  logic [BW-1:0] edA = '0, edB = '0, holdD = '0;
  logic [AW-1:0] holdA = '0;

  always #5 clk = ~clk;

  sram_port_arbiter #(
    .BITWIDTH        (BW),
    .NR_OF_ENTRIES   (NE),
    .MAX_LOCK_CYCLES (MAX)
  ) dut (
    .clock_i           (clk),
    .nReset_i          (nReset),
    .requestA_i        (requestA),
    .lockA_i           (lockA),
    .writeEnableA_i    (writeEnableA),
    .addressA_i        (addressA),
    .dataInA_i         (dataInA),
    .grantA_o          (grantA),
    .readValidA_o      (readValidA),
    .dataOutA_o        (dataOutA),
    .requestB_i        (requestB),
    .lockB_i           (lockB),
    .writeEnableB_i    (writeEnableB),
    .addressB_i        (addressB),
    .dataInB_i         (dataInB),
    .grantB_o          (grantB),
    .readValidB_o      (readValidB),
    .dataOutB_o        (dataOutB),
    .sramAddress_o     (sramAddress),
    .sramWriteEnable_o (sramWriteEnable),
    .sramDataIn_o      (sramDataIn),
    .sramDataOut_i     (sramDataOut)
  );

  // Registered-read SSRAM port
  always @(posedge clk) begin
    if (sramWriteEnable) mem[sramAddress] <= sramDataIn;
    sramDataOut <= mem[sramAddress];
  end

  function automatic logic [BW-1:0] pat(input int i);
    return (i == 5) ? 32'hDEADBEEF : (32'h1000_0000 + BW'(i));
  endfunction

  function automatic vec_t row(input bit rst, late, rA, lA, wA, input int aA,
                               input logic [BW-1:0] dA, input bit rB, lB, wB,
                               input int aB, input logic [BW-1:0] dB,
                               input bit gA, gB, vA, vB,
                               input logic [BW-1:0] oA, oB);
    vec_t v;
    v.rst = rst; v.rstLate = late;
    v.rA = rA; v.lA = lA; v.wA = wA; v.aA = AW'(aA); v.dA = dA;
    v.rB = rB; v.lB = lB; v.wB = wB; v.aB = AW'(aB); v.dB = dB;
    v.gA = gA; v.gB = gB; v.vA = vA; v.vB = vB; v.oA = oA; v.oB = oB;
    return v;
  endfunction

  task automatic chk(input string name, input logic [BW-1:0] act, input logic [BW-1:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cycle(input vec_t v, input bit useTbl);
    bit mgA, mgB, win, lockWin;
    nReset = v.rst;
    requestA = v.rA; lockA = v.lA; writeEnableA = v.wA; addressA = v.aA; dataInA = v.dA;
    requestB = v.rB; lockB = v.lB; writeEnableB = v.wB; addressB = v.aB; dataInB = v.dB;
    @(negedge clk);
    mgA = 0; mgB = 0;
    if (v.rst) begin
      if (owner == 1)      mgA = v.rA;
      else if (owner == 2) mgB = v.rB;
      else if (v.rA && v.rB) begin
        mgA = (last == 1); mgB = (last == 0);
      end else begin
        mgA = v.rA; mgB = v.rB;
      end
    end
    chk("model grantA", BW'(grantA), BW'(mgA));
    chk("model grantB", BW'(grantB), BW'(mgB));
    chk("model sramWriteEnable", BW'(sramWriteEnable),
        BW'((mgA && v.wA) || (mgB && v.wB)));
    if (mgA || mgB) begin
      chk("model sramAddress", BW'(sramAddress), BW'(mgA ? v.aA : v.aB));
      chk("model sramDataIn", sramDataIn, mgA ? v.dA : v.dB);
    end else if (haveHold) begin
      chk("model sramAddress hold", BW'(sramAddress), BW'(holdA));
      chk("model sramDataIn hold", sramDataIn, holdD);
    end
    chk("model readValidA", BW'(readValidA), BW'(evA));
    chk("model readValidB", BW'(readValidB), BW'(evB));
    chk("model dataOutA", dataOutA, evA ? edA : '0);
    chk("model dataOutB", dataOutB, evB ? edB : '0);
    if (useTbl) begin
      chk("tbl grantA", BW'(grantA), BW'(v.gA));
      chk("tbl grantB", BW'(grantB), BW'(v.gB));
      chk("tbl readValidA", BW'(readValidA), BW'(v.vA));
      chk("tbl readValidB", BW'(readValidB), BW'(v.vB));
      chk("tbl dataOutA", dataOutA, v.oA);
      chk("tbl dataOutB", dataOutB, v.oB);
    end
    nReset = v.rstLate;
    @(posedge clk);
    if (!v.rstLate) begin
      owner = 0; beats = 0; last = 1; evA = 0; evB = 0;
    end else begin
      evA = mgA && !v.wA;
      evB = mgB && !v.wB;
      if (evA) edA = shadow[v.aA];
      if (evB) edB = shadow[v.aB];
      if (mgA || mgB) begin
        win = mgB;
        lockWin = win ? v.lB : v.lA;
        if (mgA && v.wA) shadow[v.aA] = v.dA;
        if (mgB && v.wB) shadow[v.aB] = v.dB;
        last = int'(win);
        haveHold = 1;
        holdA = win ? v.aB : v.aA;
        holdD = win ? v.dB : v.dA;
        if (owner != 0) begin
          beats++;
          if (!lockWin || beats >= MAX) begin
            owner = 0; beats = 0;
          end
        end else if (lockWin) begin
          owner = int'(win) + 1; beats = 1;
        end
      end else begin
        owner = 0; beats = 0;
      end
    end
    #1;
  endtask

  vec_t tbl[$];

  initial begin
    vec_t rv;
    for (int i = 0; i < NE; i++) begin
      mem[i] <= pat(i);
      shadow[i] = pat(i);
    end
    // reset, then a single read of address 5
    for (int i = 0; i < 3; i++)
      tbl.push_back(row(0,0, 1,0,0,0,0, 0,0,0,0,0, 0,0,0,0, 0,0));
    tbl.push_back(row(1,1, 1,0,0,5,0, 0,0,0,0,0, 1,0,0,0, 0,0));
    tbl.push_back(row(1,1, 0,0,0,0,0, 1,0,0,3,0, 0,1,1,0, 32'hDEADBEEF,0));
    // tie, round-robin
    tbl.push_back(row(1,1, 1,0,0,1,0, 1,0,0,2,0, 1,0,0,1, 0,pat(3)));
    tbl.push_back(row(1,1, 1,0,0,1,0, 1,0,0,2,0, 0,1,1,0, pat(1),0));
    tbl.push_back(row(1,1, 1,0,0,1,0, 1,0,0,2,0, 1,0,0,1, 0,pat(2)));
    tbl.push_back(row(1,1, 1,0,0,1,0, 1,0,0,2,0, 0,1,1,0, pat(1),0));
    tbl.push_back(row(1,1, 0,0,0,0,0, 0,0,0,0,0, 0,0,0,1, 0,pat(2)));
    // locked write burst, released on the third beat
    tbl.push_back(row(1,1, 1,1,1,0,32'hAAAA0000, 1,0,0,1,0, 1,0,0,0, 0,0));
    tbl.push_back(row(1,1, 1,1,1,1,32'hAAAA0001, 1,0,0,1,0, 1,0,0,0, 0,0));
    tbl.push_back(row(1,1, 1,0,1,2,32'hAAAA0002, 1,0,0,1,0, 1,0,0,0, 0,0));
    tbl.push_back(row(1,1, 0,0,0,0,0, 1,0,0,1,0, 0,1,0,0, 0,0));
    tbl.push_back(row(1,1, 0,0,0,0,0, 0,0,0,0,0, 0,0,0,1, 0,32'hAAAA0001));
    // lock timeout after MAX beats
    tbl.push_back(row(1,1, 1,1,0,4,0, 1,0,0,6,0, 1,0,0,0, 0,0));
    tbl.push_back(row(1,1, 1,1,0,4,0, 1,0,0,6,0, 1,0,1,0, pat(4),0));
    tbl.push_back(row(1,1, 1,1,0,4,0, 1,0,0,6,0, 1,0,1,0, pat(4),0));
    tbl.push_back(row(1,1, 1,1,0,4,0, 1,0,0,6,0, 1,0,1,0, pat(4),0));
    tbl.push_back(row(1,1, 1,1,0,4,0, 1,0,0,6,0, 0,1,1,0, pat(4),0));
    tbl.push_back(row(1,1, 1,1,0,4,0, 1,0,0,6,0, 1,0,0,1, 0,pat(6)));
    tbl.push_back(row(1,1, 0,0,0,0,0, 0,0,0,0,0, 0,0,1,0, pat(4),0));
    // lock abandon by B
    tbl.push_back(row(1,1, 0,0,0,0,0, 1,1,0,7,0, 0,1,0,0, 0,0));
    tbl.push_back(row(1,1, 1,0,0,8,0, 0,0,0,0,0, 0,0,0,1, 0,pat(7)));
    tbl.push_back(row(1,1, 1,0,0,8,0, 0,0,0,0,0, 1,0,0,0, 0,0));
    tbl.push_back(row(1,1, 0,0,0,0,0, 0,0,0,0,0, 0,0,1,0, pat(8),0));
    // reset lands right after a granted B read
    tbl.push_back(row(1,0, 0,0,0,0,0, 1,0,0,9,0, 0,1,0,0, 0,0));
    tbl.push_back(row(0,0, 1,0,0,10,0, 1,0,0,11,0, 0,0,0,0, 0,0));
    tbl.push_back(row(1,1, 1,0,0,10,0, 1,0,0,11,0, 1,0,0,0, 0,0));
    tbl.push_back(row(1,1, 0,0,0,0,0, 0,0,0,0,0, 0,0,1,0, pat(10),0));

    nReset = 0;
    requestA = 0; lockA = 0; writeEnableA = 0; addressA = '0; dataInA = '0;
    requestB = 0; lockB = 0; writeEnableB = 0; addressB = '0; dataInB = '0;
    @(posedge clk);
    #1;
    foreach (tbl[i]) cycle(tbl[i], 1'b1);

    for (int n = 0; n < 600; n++) begin
      rv.rst     = ($urandom_range(0, 59) != 0);
      rv.rstLate = rv.rst && ($urandom_range(0, 59) != 0);
      rv.rA = ($urandom_range(0, 9) < 7); rv.lA = $urandom_range(0, 1);
      rv.wA = ($urandom_range(0, 9) < 4); rv.aA = AW'($urandom_range(0, 15));
      rv.dA = $urandom;
      rv.rB = ($urandom_range(0, 9) < 7); rv.lB = $urandom_range(0, 1);
      rv.wB = ($urandom_range(0, 9) < 4); rv.aB = AW'($urandom_range(0, 15));
      rv.dB = $urandom;
      rv.gA = 0; rv.gB = 0; rv.vA = 0; rv.vB = 0; rv.oA = '0; rv.oB = '0;
      cycle(rv, 1'b0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
